// File: rtl/dccm_banked_mem.sv
// Banked data-memory with a dual-address read port and a FIFO write buffer.
// Reads use asynchronous array reads merged with write-buffer forwarding and
// register the result. A lo/hi pair in the same bank but at different words
// takes two bank cycles. Buffered writes drain only into banks that are idle
// that cycle, because reads always have priority.
module dccm_banked_mem #(
    parameter int DATA_W    = 39,
    parameter int ADDR_W    = 16,
    parameter int NUM_BANKS = 4,
    parameter int WB_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              freeze,
    input  logic                              rden,
    input  logic [ADDR_W-1:0]                 rd_addr_lo,
    input  logic [ADDR_W-1:0]                 rd_addr_hi,
    input  logic                              wren,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              wr_ready,
    output logic [DATA_W-1:0]                 rd_data_lo,
    output logic [DATA_W-1:0]                 rd_data_hi,
    output logic                              rd_valid,
    output logic                              rd_busy,
    output logic [$clog2(WB_DEPTH+1)-1:0]     wb_count,
    output logic [15:0]                       conflict_cnt
);

    localparam int BANK_W     = $clog2(NUM_BANKS);
    localparam int WORD_W     = ADDR_W - 2;
    localparam int IDX_W      = WORD_W - BANK_W;
    localparam int BANK_DEPTH = 1 << IDX_W;
    localparam int PTR_W      = $clog2(WB_DEPTH);
    localparam int CNT_W      = $clog2(WB_DEPTH + 1);
    localparam logic [CNT_W-1:0] WB_FULL = CNT_W'(WB_DEPTH);

    logic [DATA_W-1:0] r_mem [NUM_BANKS][BANK_DEPTH];
    logic [WORD_W-1:0] r_wb_word [WB_DEPTH];
    logic [DATA_W-1:0] r_wb_data [WB_DEPTH];
    logic [PTR_W-1:0]  r_head, r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              r_valid, r_busy, r_hi_done;
    logic [WORD_W-1:0] r_hi_word;
    logic [DATA_W-1:0] r_lo_hold, r_hi_hold, r_rd_lo, r_rd_hi;
    logic [15:0]       r_conf_cnt;

    logic [WORD_W-1:0]    w_lo_word, w_hi_req_word, w_hi_word, w_head_word;
    logic                 w_accept, w_same_bank_conflict, w_hi_read;
    logic                 w_drain, w_drain_blocked, w_enq, w_conf_evt;
    logic [NUM_BANKS-1:0] w_bank_rd;
    logic [DATA_W-1:0]    w_lo_rdata, w_hi_rdata;
    logic                 w_unused_addr_bits;

    assign w_lo_word     = rd_addr_lo[ADDR_W-1:2];
    assign w_hi_req_word = rd_addr_hi[ADDR_W-1:2];
    assign w_unused_addr_bits = ^{rd_addr_lo[1:0], rd_addr_hi[1:0], wr_addr[1:0]};

    // A new read is only taken when the previous conflicted read has fully retired.
    assign w_accept  = rden && !freeze && !r_busy && !rst;
    assign w_same_bank_conflict = (w_lo_word[BANK_W-1:0] == w_hi_req_word[BANK_W-1:0])
                                  && (w_lo_word != w_hi_req_word);
    assign w_hi_word = r_busy ? r_hi_word : w_hi_req_word;
    assign w_hi_read = r_busy && !r_hi_done;

    // Youngest buffered entry for this word wins over the array contents.
    function automatic logic [DATA_W-1:0] lookup(input logic [WORD_W-1:0] word);
        logic [DATA_W-1:0] v;
        int p;
        v = r_mem[word[BANK_W-1:0]][word[WORD_W-1:BANK_W]];
        for (int i = 0; i < WB_DEPTH; i++) begin
            p = int'(r_head) + i;
            if (p >= WB_DEPTH) p = p - WB_DEPTH;
            if ((i < int'(r_count)) && (r_wb_word[PTR_W'(p)] == word))
                v = r_wb_data[PTR_W'(p)];
        end
        return v;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Read data for both ports, including forwarding from the write buffer.
    always_comb begin
        w_lo_rdata = lookup(w_lo_word);
        w_hi_rdata = lookup(w_hi_word);
    end

    // Banks occupied by reads this cycle; drains must stay out of these.
    always_comb begin
        w_bank_rd = '0;
        if (w_accept) begin
            w_bank_rd[w_lo_word[BANK_W-1:0]] = 1'b1;
            if (!w_same_bank_conflict) w_bank_rd[w_hi_req_word[BANK_W-1:0]] = 1'b1;
        end
        if (w_hi_read) w_bank_rd[r_hi_word[BANK_W-1:0]] = 1'b1;
    end

    assign w_head_word     = r_wb_word[r_head];
    assign w_drain_blocked = (r_count != '0) && w_bank_rd[w_head_word[BANK_W-1:0]];
    assign w_drain         = (r_count != '0) && !w_drain_blocked && !rst;
    assign w_enq           = wren && (r_count < WB_FULL) && !rst;
    assign w_conf_evt      = (w_accept && w_same_bank_conflict) || w_drain_blocked;

    // Array write port: the buffer head retires into its bank.
    always_ff @(posedge clk) begin
        if (w_drain)
            r_mem[w_head_word[BANK_W-1:0]][w_head_word[WORD_W-1:BANK_W]] <= r_wb_data[r_head];
    end

    // Write-buffer payload storage at the tail slot.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wb_word[r_tail] <= wr_addr[ADDR_W-1:2];
            r_wb_data[r_tail] <= wr_data;
        end
    end

    // Write-buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)   r_tail <= ptr_next(r_tail);
            if (w_drain) r_head <= ptr_next(r_head);
            if (w_enq && !w_drain)      r_count <= r_count + CNT_W'(1);
            else if (!w_enq && w_drain) r_count <= r_count - CNT_W'(1);
        end
    end

    // Read sequencing: single-cycle reads, two-cycle conflicted reads, freeze deferral.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_hi_done <= 1'b0;
            r_hi_word <= '0;
            r_lo_hold <= '0;
            r_hi_hold <= '0;
            r_rd_lo   <= '0;
            r_rd_hi   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                if (w_same_bank_conflict) begin
                    r_lo_hold <= w_lo_rdata;
                    r_hi_word <= w_hi_req_word;
                    r_busy    <= 1'b1;
                    r_hi_done <= 1'b0;
                end else begin
                    r_rd_lo <= w_lo_rdata;
                    r_rd_hi <= w_hi_rdata;
                    r_valid <= 1'b1;
                end
            end else if (r_busy) begin
                if (!freeze) begin
                    r_rd_lo <= r_lo_hold;
                    r_rd_hi <= r_hi_done ? r_hi_hold : w_hi_rdata;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                end else if (!r_hi_done) begin
                    r_hi_hold <= w_hi_rdata;
                    r_hi_done <= 1'b1;
                end
            end
        end
    end

    // Saturating count of cycles with a bank conflict (read/read or read/drain).
    always_ff @(posedge clk) begin
        if (rst)                                     r_conf_cnt <= '0;
        else if (w_conf_evt && r_conf_cnt != 16'hFFFF) r_conf_cnt <= r_conf_cnt + 16'd1;
    end

    assign wr_ready     = (r_count < WB_FULL);
    assign wb_count     = r_count;
    assign rd_data_lo   = r_rd_lo;
    assign rd_data_hi   = r_rd_hi;
    assign rd_valid     = r_valid;
    assign rd_busy      = r_busy;
    assign conflict_cnt = r_conf_cnt;

endmodule

// File: tb/tb_dccm_banked_mem.sv
// Bench for dccm_banked_mem: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_dccm_banked_mem;

    logic        clk = 1'b0;
    logic        rst, freeze, rden, wren;
    logic [15:0] rd_addr_lo, rd_addr_hi, wr_addr;
    logic [38:0] wr_data;
    logic        wr_ready, rd_valid, rd_busy;
    logic [38:0] rd_data_lo, rd_data_hi;
    logic [2:0]  wb_count;
    logic [15:0] conflict_cnt;

    int tests = 0;
    int fails = 0;

    dccm_banked_mem dut (
        .clk(clk), .rst(rst), .freeze(freeze), .rden(rden),
        .rd_addr_lo(rd_addr_lo), .rd_addr_hi(rd_addr_hi),
        .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_data_lo(rd_data_lo), .rd_data_hi(rd_data_hi),
        .rd_valid(rd_valid), .rd_busy(rd_busy), .wb_count(wb_count),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: committed memory by word, pending-write queue, one in-flight read.
    typedef struct { int word; logic [38:0] data; } wb_t;
    logic [38:0] mem_m [int];
    wb_t         q[$];
    bit          m_valid, m_busy;
    logic [38:0] m_lo, m_hi;
    logic [15:0] m_cnt;
    logic [38:0] fl_lo_val, fl_hi_val;
    int          fl_hi_word;
    bit          fl_hi_done;

    function automatic logic [38:0] peek(int w);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].word == w) return q[i].data;
        return mem_m[w];
    endfunction

    task automatic model_step();
        bit conf;
        int sz0, wl, wh;
        bit [3:0] used;
        if (rst) begin
            q.delete();
            m_valid = 0; m_busy = 0; m_lo = '0; m_hi = '0; m_cnt = '0;
            return;
        end
        conf = 0; used = '0; sz0 = q.size(); m_valid = 0;
        if (m_busy) begin
            if (!fl_hi_done) begin
                fl_hi_val = peek(fl_hi_word);
                used[fl_hi_word % 4] = 1'b1;
                fl_hi_done = 1;
            end
            if (!freeze) begin
                m_lo = fl_lo_val; m_hi = fl_hi_val; m_valid = 1; m_busy = 0;
            end
        end else if (rden && !freeze) begin
            wl = int'(rd_addr_lo >> 2);
            wh = int'(rd_addr_hi >> 2);
            used[wl % 4] = 1'b1;
            if ((wl % 4 == wh % 4) && wl != wh) begin
                fl_lo_val = peek(wl); fl_hi_word = wh; fl_hi_done = 0; m_busy = 1; conf = 1;
            end else begin
                m_lo = peek(wl); m_hi = peek(wh); m_valid = 1;
                used[wh % 4] = 1'b1;
            end
        end
        if (sz0 > 0) begin
            if (used[q[0].word % 4]) conf = 1;
            else begin
                mem_m[q[0].word] = q[0].data;
                void'(q.pop_front());
            end
        end
        if (wren && sz0 < 4) q.push_back('{int'(wr_addr >> 2), wr_data});
        if (conf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rd_valid", 64'(rd_valid), 64'(m_valid));
        chk("rd_busy", 64'(rd_busy), 64'(m_busy));
        chk("wb_count", 64'(wb_count), 64'(q.size()));
        chk("wr_ready", 64'(wr_ready), 64'(q.size() < 4));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        chk("rd_data_lo", 64'(rd_data_lo), 64'(m_lo));
        chk("rd_data_hi", 64'(rd_data_hi), 64'(m_hi));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 0; freeze = 0; rden = 0; wren = 0;
    endtask

    task automatic do_rd(input logic [15:0] lo, input logic [15:0] hi);
        rden = 1; rd_addr_lo = lo; rd_addr_hi = hi;
        tick();
        rden = 0;
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [38:0] d);
        wren = 1; wr_addr = a; wr_data = d;
        tick();
        wren = 0;
    endtask

    function automatic logic [38:0] rnd39();
        return {7'($urandom_range(0, 127)), 32'($urandom)};
    endfunction

    function automatic logic [15:0] rnd_addr();
        return 16'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
    endfunction

    logic [38:0] d_a, d_b;

    initial begin
        rst = 1; freeze = 0; rden = 0; wren = 0;
        rd_addr_lo = '0; rd_addr_hi = '0; wr_addr = '0; wr_data = '0;
        tick();
        tick();
        chk("rst_wb_count", 64'(wb_count), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        idle();

        // Populate the 16-word address pool used throughout.
        for (int i = 0; i < 16; i++) do_wr(16'(i * 4), rnd39());
        repeat (3) tick();

        // Same-bank conflicted read on an otherwise quiet memory.
        do_rd(16'h0000, 16'h0010);
        chk("conf_busy", 64'(rd_busy), 64'd1);
        chk("conf_novalid", 64'(rd_valid), 64'd0);
        tick();
        chk("conf_valid", 64'(rd_valid), 64'd1);
        chk("conf_cnt", 64'(conflict_cnt), 64'd1);
        chk("conf_done", 64'(rd_busy), 64'd0);

        // Write then read through the array once drained.
        do_wr(16'h0010, 39'h12);
        repeat (2) tick();
        chk("drained", 64'(wb_count), 64'd0);
        do_rd(16'h0010, 16'h0014);
        chk("r1_valid", 64'(rd_valid), 64'd1);
        chk("r1_lo", 64'(rd_data_lo), 64'h12);

        // Back-to-back writes to one word; read forwards the younger.
        do_wr(16'h0020, 39'hA);
        do_wr(16'h0020, 39'hB);
        do_rd(16'h0020, 16'h0024);
        chk("fwd_lo", 64'(rd_data_lo), 64'hB);
        repeat (3) tick();
        do_rd(16'h0022, 16'h0024);
        chk("order_lo", 64'(rd_data_lo), 64'hB);

        // Bank-0 read pressure fills the buffer; it drains once reads stop.
        for (int i = 0; i < 5; i++) begin
            rden = 1; rd_addr_lo = 16'h0000; rd_addr_hi = 16'h0010;
            wren = 1; wr_addr = 16'h0030; wr_data = 39'(100 + i);
            tick();
            if (i == 3) begin
                chk("full_ready", 64'(wr_ready), 64'd0);
                chk("full_count", 64'(wb_count), 64'd4);
            end
        end
        idle();
        tick();
        for (int i = 3; i >= 0; i--) begin
            tick();
            chk("drain_step", 64'(wb_count), 64'(i));
        end

        // Freeze rises during the second cycle of a conflicted read.
        do_rd(16'h0004, 16'h0014);
        freeze = 1;
        repeat (3) begin
            tick();
            chk("frz_hold", 64'(rd_valid), 64'd0);
        end
        freeze = 0;
        tick();
        chk("frz_release", 64'(rd_valid), 64'd1);

        // Reset while a conflicted read is in flight with three buffered writes.
        d_a = rnd39();
        for (int i = 0; i < 3; i++) begin
            rden = 1; rd_addr_lo = 16'h0000; rd_addr_hi = 16'h0010;
            wren = 1; wr_addr = 16'h0030; wr_data = d_a + 39'(i);
            tick();
        end
        idle();
        chk("pre_rst_busy", 64'(rd_busy), 64'd1);
        chk("pre_rst_cnt", 64'(wb_count), 64'd3);
        rst = 1; rden = 1; wren = 1;
        tick();
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_count", 64'(wb_count), 64'd0);
        chk("rst_conf", 64'(conflict_cnt), 64'd0);
        idle();
        d_b = mem_m[12];
        do_rd(16'h0030, 16'h0034);
        chk("rst_keep_mem", 64'(rd_data_lo), 64'(d_b));

        // Random traffic over the pool.
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 99) == 0);
            freeze     = ($urandom_range(0, 9) == 0);
            rden       = $urandom_range(0, 1) == 1;
            rd_addr_lo = rnd_addr();
            rd_addr_hi = rnd_addr();
            wren       = ($urandom_range(0, 9) < 4);
            wr_addr    = rnd_addr();
            wr_data    = rnd39();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dccm_banked_mem.md
DCCM_BANKED_MEM -- requirements
Module: dccm_banked_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 39, meaning stored word width (32 data + 7 ECC, opaque to this block).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning byte address width.
REQ-003 SHALL have parameter NUM_BANKS, default 4, meaning bank count, power of two, 2..16.
REQ-004 SHALL have parameter WB_DEPTH, default 4, meaning write-buffer entries, 2..8.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port freeze  in  1  holds read outputs and blocks new reads.
REQ-008 SHALL have port rden  in  1  read request.
REQ-009 SHALL have port rd_addr_lo  in  ADDR_W  first read byte address.
REQ-010 SHALL have port rd_addr_hi  in  ADDR_W  second read byte address.
REQ-011 SHALL have port wren  in  1  write request.
REQ-012 SHALL have port wr_addr  in  ADDR_W  write byte address.
REQ-013 SHALL have port wr_data  in  DATA_W  write word.
REQ-014 SHALL have port wr_ready  out  1  write buffer can accept.
REQ-015 SHALL have port rd_data_lo  out  DATA_W  word at rd_addr_lo.
REQ-016 SHALL have port rd_data_hi  out  DATA_W  word at rd_addr_hi.
REQ-017 SHALL have port rd_valid  out  1  one-cycle pulse, both read words valid.
REQ-018 SHALL have port rd_busy  out  1  second cycle of a conflicted read in progress.
REQ-019 SHALL have port wb_count  out  $clog2(WB_DEPTH+1)  buffered write count.
REQ-020 SHALL have port conflict_cnt  out  16  saturating count of bank-conflict cycles.

Function
REQ-021 SHALL decode word = addr[ADDR_W-1:2], bank = word[log2(NUM_BANKS)-1:0], index = remaining upper word bits; addr[1:0] ignored.
REQ-022 SHALL give each bank one access per cycle (read or write); storage not reset.
REQ-023 SHALL accept a read when rden && !freeze && !rd_busy; otherwise rden ignored.
REQ-024 SHALL, for an accepted read with lo/hi in different banks or same word, drive rd_data_lo/hi and rd_valid=1 the next cycle (latency 1).
REQ-025 SHALL, for lo/hi in same bank with different index, read lo in cycle N, hold rd_busy=1 in N+1, read hi in N+1, pulse rd_valid in N+2 with both words; conflict_cnt +1.
REQ-026 SHALL hold rd_data_lo/hi stable between rd_valid pulses and while freeze=1.
REQ-027 SHALL, if freeze rises while rd_busy, complete the hi read but defer the rd_valid pulse and output update until the first cycle freeze=0.
REQ-028 SHALL enqueue {word, wr_data} into a FIFO write buffer when wren && wr_ready; wr_ready = (wb_count < WB_DEPTH) from registered count only, so no enqueue when full even if a drain occurs that cycle.
REQ-029 SHALL drain the FIFO head into its bank in a cycle where that bank is not read; reads have priority; a blocked drain increments conflict_cnt (one increment per cycle even if REQ-025 also applies).
REQ-030 SHALL allow enqueue and drain in the same cycle; wb_count unchanged then.
REQ-031 SHALL forward to a read word the data of the youngest buffered entry with matching word address, else array data; a write enqueued in the same cycle as the read is not visible to it.
REQ-032 SHALL preserve write order: two buffered writes to one word leave the younger data in the array.
REQ-033 SHALL continue draining while freeze=1.
REQ-034 SHALL saturate conflict_cnt at 16'hFFFF.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, empty the write buffer (pending writes discarded), set wb_count=0, wr_ready=1, rd_valid=0, rd_busy=0, rd_data_lo/hi=0, conflict_cnt=0, aborting any in-flight read with no rd_valid.
REQ-036 SHALL ignore rden and wren in a cycle with rst=1.

Verification
REQ-037 Write 0x12 to 0x0010, idle until wb_count=0, read lo=0x0010 hi=0x0014 -> next cycle rd_valid=1, rd_data_lo=0x12.
REQ-038 Defaults: read lo=0x0000 hi=0x0010 (both bank 0) -> rd_busy=1 one cycle, rd_valid two cycles after request, conflict_cnt=1.
REQ-039 Write 0xA then 0xB to 0x0020 back-to-back, read 0x0020 next cycle -> rd_data_lo=0xB (forwarded); after drain, read again -> 0xB.
REQ-040 Continuous bank-0 reads while issuing 5 writes to bank 0 -> wr_ready=0 after 4th, wb_count=4, conflict_cnt increments each blocked cycle; stop reads -> buffer drains one per cycle.
REQ-041 Assert freeze one cycle after a conflicted read -> outputs hold, rd_valid pulses first cycle after freeze falls with correct data.
REQ-042 rst during rd_busy with wb_count=3 -> next cycle rd_valid=0, wb_count=0, conflict_cnt=0, earlier array contents unchanged.
